// File: rtl/z16_load_store_unit.sv
`timescale 1ns/1ps
// Z16 data-memory initiator: word/byte loads and stores over a single-port,
// one-cycle-read-latency memory. Define Z16_LSU_SIGN_EXT_EN to sign-extend byte loads.
//
// state   | meaning
// IDLE    | ready for a request
// READ    | address on the bus, read data arrives next cycle
// CAPTURE | load data present, format into o_rdata
// MERGE   | byte-store read data present, splice in the new byte
// WRITE   | o_mem_we high, memory writes at the closing edge
module z16_load_store_unit #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 16
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_req,
  output logic              o_ready,
  input  logic              i_we,
  input  logic              i_byte,
  input  logic [ADDR_W-1:0] i_addr,
  input  logic [DATA_W-1:0] i_wdata,
  output logic              o_valid,
  output logic [DATA_W-1:0] o_rdata,
  output logic [ADDR_W-1:0] o_mem_addr,
  output logic              o_mem_we,
  output logic [DATA_W-1:0] o_mem_data,
  input  logic [DATA_W-1:0] i_mem_data
);

  typedef enum logic [2:0] {IDLE, READ, CAPTURE, MERGE, WRITE} state_t;

  state_t      state;
  logic        lat_we;
  logic        lat_byte;
  logic        lat_lane;
  logic [7:0]  lat_wbyte;
  logic [7:0]  sel_byte;
  logic [DATA_W-1:0] byte_ext;
  logic [DATA_W-1:0] merged;

  assign o_ready  = (state == IDLE) && !i_rst;
  assign sel_byte = lat_lane ? i_mem_data[15:8] : i_mem_data[7:0];

`ifdef Z16_LSU_SIGN_EXT_EN
  assign byte_ext = {{8{sel_byte[7]}}, sel_byte};
`else
  assign byte_ext = {8'h00, sel_byte};
`endif

  // Little-endian lane replacement for read-modify-write byte stores
  assign merged = lat_lane ? {lat_wbyte, i_mem_data[7:0]}
                           : {i_mem_data[15:8], lat_wbyte};

  // o_mem_addr doubles as the latched (aligned) request address.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state      <= IDLE;
      lat_we     <= 1'b0;
      lat_byte   <= 1'b0;
      lat_lane   <= 1'b0;
      lat_wbyte  <= 8'h00;
      o_valid    <= 1'b0;
      o_rdata    <= '0;
      o_mem_addr <= '0;
      o_mem_we   <= 1'b0;
      o_mem_data <= '0;
    end else begin
      o_valid  <= 1'b0;
      o_mem_we <= 1'b0;
      case (state)
        IDLE: begin
          if (i_req) begin
            lat_we     <= i_we;
            lat_byte   <= i_byte;
            lat_lane   <= i_addr[0];
            lat_wbyte  <= i_wdata[7:0];
            o_mem_addr <= {i_addr[ADDR_W-1:1], 1'b0};
            if (i_we && !i_byte) begin
              o_mem_data <= i_wdata;
              o_mem_we   <= 1'b1;
              state      <= WRITE;
            end else begin
              state <= READ;
            end
          end
        end
        READ: state <= lat_we ? MERGE : CAPTURE;
        CAPTURE: begin
          o_rdata <= lat_byte ? byte_ext : i_mem_data;
          o_valid <= 1'b1;
          state   <= IDLE;
        end
        MERGE: begin
          o_mem_data <= merged;
          o_mem_we   <= 1'b1;
          state      <= WRITE;
        end
        WRITE: begin
          o_valid <= 1'b1;
          state   <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_z16_load_store_unit.sv
`timescale 1ns/1ps
// Directed bench for z16_load_store_unit with a one-cycle-latency memory model.
module tb_z16_load_store_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        req;
  logic        ready;
  logic        we;
  logic        byt;
  logic [15:0] addr;
  logic [15:0] wdata;
  logic        valid;
  logic [15:0] rdata;
  logic [15:0] mem_addr;
  logic        mem_we;
  logic [15:0] mem_data;
  logic [15:0] mem_rdata;

  logic [15:0] mem [0:255];

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  z16_load_store_unit dut (
    .i_clk      (clk),
    .i_rst      (rst),
    .i_req      (req),
    .o_ready    (ready),
    .i_we       (we),
    .i_byte     (byt),
    .i_addr     (addr),
    .i_wdata    (wdata),
    .o_valid    (valid),
    .o_rdata    (rdata),
    .o_mem_addr (mem_addr),
    .o_mem_we   (mem_we),
    .o_mem_data (mem_data),
    .i_mem_data (mem_rdata)
  );

  always @(posedge clk) begin
    if (mem_we) mem[mem_addr[8:1]] <= mem_data;
    mem_rdata <= mem[mem_addr[8:1]];
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Issue one request from a post-edge sample point; returns at the o_valid cycle.
  task automatic op(input logic w, input logic b, input logic [15:0] a,
                    input logic [15:0] d, input int exp_lat, input string tag);
    int lat;
    int we_cnt;
    int we_cyc;
    req = 1'b1; we = w; byt = b; addr = a; wdata = d;
    @(posedge clk); #1;
    req = 1'b0;
    lat = 1; we_cnt = 0; we_cyc = 0;
    while (!valid && lat < 20) begin
      if (mem_we) begin we_cnt++; we_cyc = lat; end
      @(posedge clk); #1;
      lat++;
    end
    if (mem_we) we_cnt++;
    chk({tag, "_lat"}, lat, exp_lat);
    chk({tag, "_we_cnt"}, we_cnt, w ? 1 : 0);
    if (w) chk({tag, "_we_cyc"}, we_cyc, exp_lat - 1);
  endtask

  initial begin
    int cyc;
    int k;
    int seen_we;
    int seen_valid;
    logic [15:0] b2b_addr [3];
    logic [15:0] b2b_exp [3];
    logic [15:0] exp_b1;

    rst = 1'b1; req = 1'b0; we = 1'b0; byt = 1'b0; addr = '0; wdata = '0;
    repeat (2) @(posedge clk); #1;
    chk("rst_ready", ready, 0);
    chk("rst_valid", valid, 0);
    chk("rst_rdata", rdata, 16'h0000);
    chk("rst_mem_addr", mem_addr, 16'h0000);
    chk("rst_mem_we", mem_we, 0);
    chk("rst_mem_data", mem_data, 16'h0000);
    rst = 1'b0;
    @(posedge clk); #1;
    chk("ready_after_rst", ready, 1);

    op(1, 0, 16'h0100, 16'h5555, 2, "wst");
    chk("wst_mem", mem[8'h80], 16'h5555);
    chk("wst_ready_in_valid", ready, 1);
    @(posedge clk); #1;
    chk("wst_valid_one_cycle", valid, 0);

    op(0, 0, 16'h0100, 16'h0000, 3, "wld");
    chk("wld_rdata", rdata, 16'h5555);

    op(1, 1, 16'h0101, 16'h12AA, 4, "bst_hi");
    chk("bst_hi_mem", mem[8'h80], 16'hAA55);
    chk("bst_keeps_rdata", rdata, 16'h5555);
    chk("bst_hi_mem_data", mem_data, 16'hAA55);

    op(0, 0, 16'h0100, 16'h0000, 3, "wld2");
    chk("wld2_rdata", rdata, 16'hAA55);

`ifdef Z16_LSU_SIGN_EXT_EN
    exp_b1 = 16'hFFAA;
`else
    exp_b1 = 16'h00AA;
`endif
    op(0, 1, 16'h0101, 16'h0000, 3, "bld_hi");
    chk("bld_hi_rdata", rdata, exp_b1);
    op(0, 1, 16'h0100, 16'h0000, 3, "bld_lo");
    chk("bld_lo_rdata", rdata, 16'h0055);

    op(1, 1, 16'h0100, 16'hFF33, 4, "bst_lo");
    chk("bst_lo_mem", mem[8'h80], 16'hAA33);

    // Word accesses at an odd address align down
    op(1, 0, 16'h0101, 16'h1234, 2, "wst_odd");
    chk("wst_odd_mem", mem[8'h80], 16'h1234);
    op(0, 0, 16'h0101, 16'h0000, 3, "wld_odd");
    chk("wld_odd_rdata", rdata, 16'h1234);
    chk("wld_odd_mem_addr", mem_addr, 16'h0100);

    op(1, 0, 16'h0102, 16'hBEEF, 2, "wst_b");
    op(1, 0, 16'h0104, 16'hC0DE, 2, "wst_c");

    b2b_addr[0] = 16'h0100; b2b_exp[0] = 16'h1234;
    b2b_addr[1] = 16'h0102; b2b_exp[1] = 16'hBEEF;
    b2b_addr[2] = 16'h0104; b2b_exp[2] = 16'hC0DE;
    req = 1'b1; we = 1'b0; byt = 1'b0; addr = b2b_addr[0];
    cyc = 0; k = 0;
    while (k < 3 && cyc < 30) begin
      @(posedge clk); #1;
      cyc++;
      if (valid) begin
        chk($sformatf("b2b%0d_rdata", k), rdata, b2b_exp[k]);
        chk($sformatf("b2b%0d_cycle", k), cyc, 3 * (k + 1));
        k++;
        if (k < 3) addr = b2b_addr[k];
        else req = 1'b0;
      end
    end
    req = 1'b0;
    chk("b2b_count", k, 3);

    // Request toggled while busy must not be queued
    req = 1'b1; addr = 16'h0102;
    @(posedge clk); #1;
    chk("busy_ready_c1", ready, 0);
    req = 1'b0; addr = 16'h0104;
    @(posedge clk); #1;
    chk("busy_ready_c2", ready, 0);
    chk("busy_valid_c2", valid, 0);
    req = 1'b1;
    @(posedge clk); #1;
    chk("busy_valid_c3", valid, 1);
    chk("busy_rdata", rdata, 16'hBEEF);
    req = 1'b0;
    seen_valid = 0;
    repeat (5) begin
      @(posedge clk); #1;
      if (valid) seen_valid++;
    end
    chk("busy_no_extra", seen_valid, 0);
    chk("busy_rdata_hold", rdata, 16'hBEEF);

    // Reset during MERGE of a byte store
    op(1, 0, 16'h0100, 16'h5555, 2, "wst_pre");
    req = 1'b1; we = 1'b1; byt = 1'b1; addr = 16'h0100; wdata = 16'h0077;
    @(posedge clk); #1;
    req = 1'b0;
    seen_we = mem_we ? 1 : 0;
    @(posedge clk); #1;
    if (mem_we) seen_we++;
    #2 rst = 1'b1;
    #1;
    chk("arst_mem_we", mem_we, 0);
    chk("arst_valid", valid, 0);
    chk("arst_ready", ready, 0);
    chk("arst_rdata", rdata, 16'h0000);
    chk("arst_mem_addr", mem_addr, 16'h0000);
    chk("arst_mem_data", mem_data, 16'h0000);
    @(posedge clk); #1;
    rst = 1'b0;
    seen_valid = 0;
    repeat (6) begin
      @(posedge clk); #1;
      if (mem_we) seen_we++;
      if (valid) seen_valid++;
    end
    chk("arst_no_write", seen_we, 0);
    chk("arst_no_valid", seen_valid, 0);
    chk("arst_mem_kept", mem[8'h80], 16'h5555);
    chk("arst_ready_after", ready, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/z16_load_store_unit.md
# z16_load_store_unit

Initiator side of the Z16 data-memory interface. It accepts load/store requests from the core's execute stage over a valid/ready handshake and sequences the data memory's single-port, one-cycle-read-latency access. It adds byte loads and stores, using read-modify-write for byte stores, and returns formatted load data with a one-cycle completion pulse.

## Interface
- ADDR_W, 16, byte address width
- DATA_W, 16, memory word width; only 16 is supported
- i_clk  in  1  clock; all registers update on the rising edge
- i_rst  in  1  reset, asynchronous, active-high
- i_req  in  1  request valid from core
- o_ready  out  1  unit idle and able to accept a request
- i_we  in  1  1 = store, 0 = load
- i_byte  in  1  1 = byte access selected by i_addr[0], 0 = word access
- i_addr  in  ADDR_W  byte address
- i_wdata  in  DATA_W  store data; byte stores use i_wdata[7:0]
- o_valid  out  1  one-cycle completion pulse, for loads and stores
- o_rdata  out  DATA_W  load result
- o_mem_addr  out  ADDR_W  memory address, always even: {addr[15:1],1'b0}
- o_mem_we  out  1  memory write enable; the memory writes at the rising edge while this is high
- o_mem_data  out  DATA_W  memory write data
- i_mem_data  in  DATA_W  memory read data, valid in the cycle after an address is held across a rising edge

## Operation
- Accept occurs on a rising edge with i_req=1 and o_ready=1. On accept, the unit latches i_we, i_byte, i_addr and i_wdata.
- When busy, i_req is ignored and not queued. The core re-presents the request.
- o_ready = (state==IDLE) and not i_rst.
- States: IDLE, READ, CAPTURE, MERGE, WRITE.
- Word store: IDLE → WRITE → IDLE.
- Word load: IDLE → READ → CAPTURE → IDLE.
- Byte store: IDLE → READ → MERGE → WRITE → IDLE.
- In READ, MERGE and WRITE, o_mem_addr is driven from the latched address.
- In MERGE, the write buffer is loaded with i_mem_data, with the byte lane for addr[0] replaced by wdata[7:0].
- Byte ordering is little-endian: addr[0]=0 selects bits [7:0]; addr[0]=1 selects bits [15:8].
- In CAPTURE, o_rdata is loaded from i_mem_data:
  - word load: the full word
  - byte load: the selected byte, extended per Configuration
- o_mem_we=1 only in WRITE. In WRITE, o_mem_data is the write buffer. In all other states o_mem_data holds the buffer's last value.
- A word access with addr[0]=1 is aligned down. Bit 0 is ignored and no error is raised.
- o_rdata holds its value until the next load completes. Stores never modify o_rdata.
- o_valid is registered. It is high for exactly one cycle, in the cycle after the edge that leaves WRITE or CAPTURE.

## Timing
Latency is counted from the accept edge E0 to the cycle in which o_valid is high:
- word store: memory written at E1; o_valid high in cycle 2
- word load: o_rdata valid in cycle 3, with o_valid high
- byte store: memory written at E3; o_valid high in cycle 4
- byte load: same as word load (cycle 3)

Back-to-back requests:
- o_ready is high in the o_valid cycle, so a new request can be accepted at that cycle's edge. There are zero idle cycles between requests.

Reset:
- Reset values: state IDLE, o_valid 0, o_rdata 0x0000, o_mem_addr 0x0000, o_mem_we 0, o_mem_data 0x0000, all latched request fields 0.
- Reset mid-operation aborts the operation immediately and asynchronously:
  - o_mem_we drops in the same cycle.
  - Memory is not written unless the WRITE edge already occurred.
  - No o_valid is produced for the aborted request.
- o_ready is 0 while i_rst is high. It becomes 1 in the first cycle after deassertion.

## Configuration
- Z16_LSU_SIGN_EXT_EN defined: byte loads are sign-extended from bit 7. Example: 0xAA → 0xFFAA.
- Z16_LSU_SIGN_EXT_EN undefined: byte loads are zero-extended. Example: 0xAA → 0x00AA.
- Word accesses and all timing are identical in both builds.

## Test plan
- Word store 0x5555 to 0x0100, then word load 0x0100 → o_mem_we high for exactly one cycle; o_valid in cycle 2 after the store; o_rdata=0x5555 with o_valid in cycle 3 after the load.
- Memory word 0x0100=0x5555; byte store i_wdata=0x12AA to 0x0101 → single write of 0xAA55 at E3; o_valid in cycle 4; then word load returns 0xAA55.
- Memory word 0x0100=0xAA55; byte load 0x0101 → 0x00AA without the macro, 0xFFAA with it. Byte load 0x0100 → 0x0055 in both builds.
- i_req held high with three word loads presented back to back → each accepted in the previous o_valid cycle; o_valid every 3 cycles. i_req toggled while busy → no extra accepts.
- Reset pulsed during MERGE of a byte store to 0x0100 (memory 0x5555) → o_mem_we never high; memory still 0x5555; all outputs at reset values; no o_valid.
- Word load 0x0101 with memory 0x0100=0x1234 → o_mem_addr=0x0100; o_rdata=0x1234.
